// File: rtl/inst_enc.sv
// inst_enc: packs opcode, register and immediate fields into a 32-bit instruction word behind a
// valid/ready pipeline stage. Define INST_ENC_LI_EXPAND_EN to expand wide load-immediates into LUI(+ADDI).
module inst_enc (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [2:0]  in_fmt,
   input  logic [6:0]  in_opc,
   input  logic [2:0]  in_funct3,
   input  logic [6:0]  in_funct7,
   input  logic [4:0]  in_rd,
   input  logic [4:0]  in_rs1,
   input  logic [4:0]  in_rs2,
   input  logic [31:0] in_imm,
   input  logic [11:0] in_csr,
   input  logic        in_li,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_inst,
   output logic        out_err
);
   localparam logic [2:0] FMT_I = 3'b001;
   localparam logic [2:0] FMT_S = 3'b010;
   localparam logic [2:0] FMT_U = 3'b011;
   localparam logic [2:0] FMT_J = 3'b100;
   localparam logic [2:0] FMT_B = 3'b101;
   localparam logic [2:0] FMT_Z = 3'b110;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
`ifdef INST_ENC_LI_EXPAND_EN
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
`endif

   typedef enum logic [1:0] {IDLE, ONE, LUI} state_t;

   state_t      state_reg;
   logic        out_valid_reg;
   logic        out_err_reg;
   logic [31:0] out_inst_reg;
   logic [31:0] addi_reg;

   logic [31:0] enc_inst_next;
   logic [31:0] enc_addi_next;
   logic        enc_err_next;
   logic        enc_two_next;
   logic        fits_12;
   logic        fits_13;
   logic        fits_21;
   logic [11:0] li_lo;
   logic        accept;

   // A signed immediate fits N bits when every bit from N-1 upward matches the sign.
   assign fits_12 = (&in_imm[31:11]) | ~(|in_imm[31:11]);
   assign fits_13 = (&in_imm[31:12]) | ~(|in_imm[31:12]);
   assign fits_21 = (&in_imm[31:20]) | ~(|in_imm[31:20]);
   assign li_lo   = in_imm[11:0];

`ifdef INST_ENC_LI_EXPAND_EN
   logic [19:0] li_hi;
   // ADDI sign-extends its 12-bit operand, so the upper part absorbs a borrow from bit 11.
   assign li_hi = in_imm[31:12] + {19'd0, in_imm[11]};
`endif

   always_comb begin
      enc_inst_next = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opc};
      enc_addi_next = '0;
      enc_err_next  = 1'b0;
      enc_two_next  = 1'b0;
      if (in_li) begin
`ifdef INST_ENC_LI_EXPAND_EN
         if (fits_12) begin
            enc_inst_next = {li_lo, 5'd0, 3'b000, in_rd, OPC_OP_IMM};
         end else begin
            enc_inst_next = {li_hi, in_rd, OPC_LUI};
            enc_addi_next = {li_lo, in_rd, 3'b000, in_rd, OPC_OP_IMM};
            enc_two_next  = |li_lo;
         end
`else
         enc_inst_next = {li_lo, 5'd0, 3'b000, in_rd, OPC_OP_IMM};
         enc_err_next  = ~fits_12;
`endif
      end else begin
         case (in_fmt)
            FMT_I: begin
               enc_inst_next = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opc};
               enc_err_next  = ~fits_12;
            end
            FMT_S: begin
               enc_inst_next = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opc};
               enc_err_next  = ~fits_12;
            end
            FMT_U: begin
               enc_inst_next = {in_imm[31:12], in_rd, in_opc};
               enc_err_next  = |in_imm[11:0];
            end
            FMT_J: begin
               enc_inst_next = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opc};
               enc_err_next  = ~fits_21 | in_imm[0];
            end
            FMT_B: begin
               enc_inst_next = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                                in_imm[4:1], in_imm[11], in_opc};
               enc_err_next  = ~fits_13 | in_imm[0];
            end
            FMT_Z: begin
               enc_inst_next = {in_csr, in_imm[4:0], in_funct3, in_rd, in_opc};
               enc_err_next  = |in_imm[31:5];
            end
            default: begin
               enc_inst_next = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opc};
               enc_err_next  = 1'b0;
            end
         endcase
      end
   end

   // A held word may be replaced in the same cycle it is consumed, giving back-to-back output.
   assign in_ready = (state_reg == IDLE) | ((state_reg == ONE) & out_ready);
   assign accept   = in_valid & in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         out_valid_reg <= 1'b0;
         out_inst_reg  <= '0;
         out_err_reg   <= 1'b0;
         addi_reg      <= '0;
      end else begin
         case (state_reg)
            IDLE, ONE: begin
               if (accept) begin
                  out_valid_reg <= 1'b1;
                  out_inst_reg  <= enc_inst_next;
                  out_err_reg   <= enc_err_next;
                  addi_reg      <= enc_addi_next;
                  state_reg     <= enc_two_next ? LUI : ONE;
               end else if ((state_reg == IDLE) || out_ready) begin
                  out_valid_reg <= 1'b0;
                  state_reg     <= IDLE;
               end
            end
            LUI: begin
               if (out_ready) begin
                  out_inst_reg <= addi_reg;
                  out_err_reg  <= 1'b0;
                  state_reg    <= ONE;
               end
            end
            default: begin
               out_valid_reg <= 1'b0;
               state_reg     <= IDLE;
            end
         endcase
      end
   end

   assign out_valid = out_valid_reg;
   assign out_inst  = out_inst_reg;
   assign out_err   = out_err_reg;

endmodule

// File: tb/tb_inst_enc.sv
// Scoreboard bench for inst_enc: a reference model queues expected words at acceptance and a
// monitor compares each word as the consumer takes it.
module tb_inst_enc;
   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_fmt;
   logic [6:0]  in_opc;
   logic [2:0]  in_funct3;
   logic [6:0]  in_funct7;
   logic [4:0]  in_rd;
   logic [4:0]  in_rs1;
   logic [4:0]  in_rs2;
   logic [31:0] in_imm;
   logic [11:0] in_csr;
   logic        in_li;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_inst;
   logic        out_err;

   int          checks = 0;
   int          passes = 0;
   int          word_no = 0;
   bit          rand_en = 1'b0;
   logic        forced_ready = 1'b0;
   logic [31:0] exp_inst_q[$];
   logic        exp_err_q[$];
   logic [31:0] imm_tab[16];

   always #5 clk = ~clk;

   inst_enc dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_fmt(in_fmt), .in_opc(in_opc), .in_funct3(in_funct3), .in_funct7(in_funct7),
      .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm), .in_csr(in_csr),
      .in_li(in_li), .out_valid(out_valid), .out_ready(out_ready),
      .out_inst(out_inst), .out_err(out_err)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s actual=%h required=%h", name, act, req);
   endtask

   task automatic check_bit(input string name, input logic act, input logic req);
      checks++;
      if (act === req) passes++;
      else $display("FAIL %s actual=%b required=%b", name, act, req);
   endtask

   task automatic push(input logic [31:0] inst, input logic err);
      exp_inst_q.push_back(inst);
      exp_err_q.push_back(err);
   endtask

   // Reference model: range rules as signed integer bounds, li split as rounded division by 4096.
   task automatic model(input logic li, input logic [2:0] fmt, input logic [6:0] opc,
                        input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                        input logic [11:0] csr);
      int sv;
      bit fit12;
      logic [31:0] hi;
      sv    = $signed(imm);
      fit12 = (sv >= -2048) && (sv <= 2047);
      hi    = (imm + 32'h800) >> 12;
      if (li) begin
`ifdef INST_ENC_LI_EXPAND_EN
         if (fit12) push({imm[11:0], 5'd0, 3'd0, rd, 7'h13}, 1'b0);
         else begin
            push({hi[19:0], rd, 7'h37}, 1'b0);
            if (imm[11:0] != 12'd0) push({imm[11:0], rd, 3'd0, rd, 7'h13}, 1'b0);
         end
`else
         push({imm[11:0], 5'd0, 3'd0, rd, 7'h13}, !fit12);
`endif
      end else begin
         case (fmt)
            3'd1: push({imm[11:0], rs1, f3, rd, opc}, !fit12);
            3'd2: push({imm[11:5], rs2, rs1, f3, imm[4:0], opc}, !fit12);
            3'd3: push({imm[31:12], rd, opc}, (imm % 32'd4096) != 32'd0);
            3'd4: push({imm[20], imm[10:1], imm[11], imm[19:12], rd, opc},
                       !(sv >= -1048576 && sv <= 1048575) || (sv % 2 != 0));
            3'd5: push({imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc},
                       !(sv >= -4096 && sv <= 4095) || (sv % 2 != 0));
            3'd6: push({csr, imm[4:0], f3, rd, opc}, imm > 32'd31);
            default: push({f7, rs2, rs1, f3, rd, opc}, 1'b0);
         endcase
      end
   endtask

   task automatic set_fields(input logic li, input logic [2:0] fmt, input logic [6:0] opc,
                             input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [31:0] imm);
      in_li = li; in_fmt = fmt; in_opc = opc; in_funct3 = 3'd0; in_funct7 = 7'd0;
      in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm; in_csr = 12'd0;
   endtask

   task automatic rand_fields();
      in_li     = ($urandom_range(0, 5) == 0);
      in_fmt    = 3'($urandom_range(0, 7));
      in_opc    = 7'($urandom);
      in_funct3 = 3'($urandom);
      in_funct7 = 7'($urandom);
      in_rd     = 5'($urandom);
      in_rs1    = 5'($urandom);
      in_rs2    = 5'($urandom);
      in_csr    = 12'($urandom);
      case ($urandom_range(0, 3))
         0: in_imm = $urandom;
         1: in_imm = 32'($urandom_range(0, 8191)) - 32'd4096;
         2: in_imm = imm_tab[$urandom_range(0, 15)];
         default: in_imm = ($urandom_range(0, 1) ? 32'hFFF0_0000 : 32'd0) | 32'($urandom_range(0, 1048575));
      endcase
   endtask

   // Holds in_valid until accepted; the expected words are queued on the accepting cycle.
   task automatic issue(input bit use_model);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      for (int c = 0; c < 60 && !done; c++) begin
         @(negedge clk);
         if (in_ready) begin
            if (use_model) model(in_li, in_fmt, in_opc, in_funct3, in_funct7, in_rd, in_rs1,
                                 in_rs2, in_imm, in_csr);
            done = 1'b1;
         end
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
      check_bit("accept_within_bound", done, 1'b1);
   endtask

   task automatic drain();
      int c;
      c = 0;
      while (exp_inst_q.size() != 0 && c < 300) begin
         @(posedge clk);
         c++;
      end
      check("drain_pending", 32'(exp_inst_q.size()), 32'd0);
      @(posedge clk);
      #1;
   endtask

   always @(posedge clk) begin
      #1;
      if (rand_en) out_ready = ($urandom_range(0, 3) != 0);
      else out_ready = forced_ready;
   end

   // Monitor: a word is taken when out_valid&out_ready hold before the coming edge.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_inst_q.size() == 0) begin
            check("unexpected_word", out_inst, 32'hxxxx_xxxx);
         end else begin
            word_no++;
            check("word_inst", out_inst, exp_inst_q[0]);
            check_bit("word_err", out_err, exp_err_q[0]);
            $display("word %0d inst=%h err=%b expected=%h/%b", word_no, out_inst, out_err,
                     exp_inst_q[0], exp_err_q[0]);
            void'(exp_inst_q.pop_front());
            void'(exp_err_q.pop_front());
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      imm_tab = '{32'd2047, 32'd2048, 32'hFFFF_F800, 32'hFFFF_F7FF, 32'd4095, 32'd4096,
                  32'hFFFF_F000, 32'hFFFF_EFFF, 32'd1048575, 32'd1048576, 32'hFFF0_0000,
                  32'd31, 32'd32, 32'd0, 32'h1234_5000, 32'h1234_5FFF};
      rst = 1'b1;
      in_valid = 1'b0;
      set_fields(1'b0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_bit("rst_out_valid", out_valid, 1'b0);
      check("rst_out_inst", out_inst, 32'd0);
      check_bit("rst_out_err", out_err, 1'b0);
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check_bit("rst_in_ready", in_ready, 1'b1);
      forced_ready = 1'b1;
      @(posedge clk);
      #1;

      // Known-answer words.
      set_fields(1'b0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd5);
      push(32'h0050_0093, 1'b0); issue(1'b0);
      set_fields(1'b0, 3'd5, 7'h63, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC);
      push(32'hFE00_0EE3, 1'b0); issue(1'b0);
      set_fields(1'b0, 3'd5, 7'h63, 5'd0, 5'd0, 5'd0, 32'd2);
      push(32'h0000_0163, 1'b0); issue(1'b0);
      set_fields(1'b0, 3'd5, 7'h63, 5'd0, 5'd0, 5'd0, 32'd3);
      push(32'h0000_0163, 1'b1); issue(1'b0);
      set_fields(1'b0, 3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 32'd2048);
      push(32'h8000_0093, 1'b1); issue(1'b0);
      drain();

      // Backpressure: word must hold for 5 cycles, then release with a new request.
      forced_ready = 1'b0;
      @(posedge clk);
      #1;
      rand_fields();
      in_li = 1'b0; in_fmt = 3'd1;
      issue(1'b1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check_bit("hold_valid", out_valid, 1'b1);
         if (exp_inst_q.size() != 0) check("hold_inst", out_inst, exp_inst_q[0]);
         check_bit("hold_in_ready", in_ready, 1'b0);
      end
      forced_ready = 1'b1;
      @(posedge clk);
      #1;
      rand_fields();
      in_li = 1'b0; in_fmt = 3'd2;
      issue(1'b1);
      @(negedge clk);
      check_bit("no_bubble_valid", out_valid, 1'b1);
      drain();

`ifdef INST_ENC_LI_EXPAND_EN
      set_fields(1'b1, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
      push(32'h1234_62B7, 1'b0);
      push(32'hFFF2_8293, 1'b0);
      issue(1'b0);
      @(negedge clk);
      check_bit("lui_in_ready", in_ready, 1'b0);
      drain();

      // Reset while the LUI word is held drops the pending ADDI.
      forced_ready = 1'b0;
      @(posedge clk);
      #1;
      set_fields(1'b1, 3'd0, 7'd0, 5'd7, 5'd0, 5'd0, 32'h7FFF_F123);
      issue(1'b1);
      @(negedge clk);
      check_bit("lui_held_valid", out_valid, 1'b1);
      check_bit("lui_held_in_ready", in_ready, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_inst_q.delete();
      exp_err_q.delete();
      forced_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         check_bit("lui_rst_valid", out_valid, 1'b0);
      end
`endif

      // Reset while a single word is held.
      forced_ready = 1'b0;
      @(posedge clk);
      #1;
      set_fields(1'b0, 3'd1, 7'h13, 5'd3, 5'd4, 5'd0, 32'd100);
      issue(1'b1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      exp_inst_q.delete();
      exp_err_q.delete();
      @(negedge clk);
      check_bit("mid_rst_valid", out_valid, 1'b0);
      check("mid_rst_inst", out_inst, 32'd0);
      check_bit("mid_rst_err", out_err, 1'b0);
      check_bit("mid_rst_in_ready", in_ready, 1'b1);
      forced_ready = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic with random consumer backpressure.
      rand_en = 1'b1;
      for (int t = 0; t < 300; t++) begin
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
         end
         rand_fields();
         issue(1'b1);
      end
      rand_en = 1'b0;
      forced_ready = 1'b1;
      drain();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_bit("final_idle_valid", out_valid, 1'b0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/inst_enc.md
INST_ENC -- requirements
Module: inst_enc

Interface
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 in_valid  input  1  request present.
REQ-004 in_ready  output  1  request accepted when in_valid&in_ready at clk edge.
REQ-005 in_fmt  input  3  immediate format: 000 none, 001 I, 010 S, 011 U, 100 J, 101 B, 110 Z; 111 treated as none.
REQ-006 in_opc  input  7  opcode, placed at inst[6:0].
REQ-007 in_funct3  input  3  placed at inst[14:12], except U/J formats.
REQ-008 in_funct7  input  7  placed at inst[31:25], none format only.
REQ-009 in_rd, in_rs1, in_rs2  input  5 each  register indices.
REQ-010 in_imm  input  32  immediate value, two's complement; Z format uses in_imm[4:0].
REQ-011 in_csr  input  12  CSR address, placed at inst[31:20], Z format only.
REQ-012 in_li  input  1  load-immediate pseudo-op; ignores in_fmt/in_opc/in_funct3 and encodes in_imm into in_rd.
REQ-013 out_valid  output  1  out_inst valid.
REQ-014 out_ready  input  1  consumer takes word when out_valid&out_ready at clk edge.
REQ-015 out_inst  output  32  encoded instruction.
REQ-016 out_err  output  1  in_imm not representable in chosen format; qualified by out_valid.

Function
REQ-017 Field packing: I {imm[11:0],rs1,f3,rd,opc}; S {imm[11:5],rs2,rs1,f3,imm[4:0],opc}; B {imm[12],imm[10:5],rs2,rs1,f3,imm[4:1],imm[11],opc}; U {imm[31:12],rd,opc}; J {imm[20],imm[10:1],imm[11],imm[19:12],rd,opc}; Z {csr,imm[4:0],f3,rd,opc}; none {f7,rs2,rs1,f3,rd,opc}.
REQ-018 Range: I/S need imm[31:11] all equal; B needs imm[31:12] all equal and imm[0]=0; J needs imm[31:20] all equal and imm[0]=0; U needs imm[11:0]=0; Z needs imm[31:5]=0; none never errors.
REQ-019 On range failure, out_err=1 and out_inst still carries the truncated fields per REQ-017.
REQ-020 Output is registered: word appears one cycle after acceptance; no combinational path from in_* to out_*.
REQ-021 States: IDLE (out_valid=0), ONE (holds single or final word), LUI (holds LUI, ADDI pending).
REQ-022 in_ready=1 in IDLE, and in ONE when out_ready=1; in_ready=0 in LUI.
REQ-023 IDLE: on accept, go to ONE, or to LUI for a two-word in_li.
REQ-024 ONE: out_ready=1 with new accept reloads ONE/LUI back-to-back; out_ready=1 with no accept goes to IDLE; out_ready=0 holds out_inst/out_err stable.
REQ-025 LUI: on out_ready=1, load ADDI word and go to ONE; otherwise hold.
REQ-026 in_li split: lo=imm[11:0], hi=imm[31:12]+imm[11] (mod 2^20).
REQ-027 in_li with imm fitting 12-bit signed emits single ADDI rd,x0,lo (opc 0010011, f3 000).
REQ-028 in_li otherwise: LUI rd,hi (opc 0110111), then ADDI rd,rd,lo only if lo!=0; in_li never sets out_err when expansion is compiled in.

Reset
REQ-029 rst=1 forces IDLE, out_valid=0, out_inst=0, out_err=0 next edge; in_ready=1 after reset.
REQ-030 Reset in LUI discards the pending ADDI; no word is emitted for it.

Configuration
REQ-031 Macro INST_ENC_LI_EXPAND_EN: defined enables REQ-026..REQ-028 and the LUI state.
REQ-032 Without INST_ENC_LI_EXPAND_EN: in_li always emits single ADDI rd,x0,imm[11:0], sets out_err when imm is outside 12-bit signed, and LUI state is never entered.

Verification
REQ-033 fmt=I, opc=0x13, f3=0, rd=1, rs1=0, imm=5 -> one cycle later out_inst=0x00500093, out_err=0.
REQ-034 fmt=B, opc=0x63, f3=0, rs1=rs2=0, imm=-4 -> out_inst=0xFE000EE3; imm=2 (bit0 unused but legal) -> out_err=0; imm=3 -> out_err=1.
REQ-035 in_li, rd=5, imm=0x12345FFF (macro on) -> 0x123462B7 then 0xFFF28293, in_ready=0 between the two words.
REQ-036 fmt=I, imm=2048 -> out_err=1, out_inst[31:20]=0x800.
REQ-037 out_ready=0 for 5 cycles with out_valid=1 -> out_inst stable, in_ready=0; release with new in_valid -> back-to-back words, no bubble.
REQ-038 rst asserted while LUI word held -> next cycle out_valid=0, ADDI never appears.
